// File: rtl/aes_chain_sequencer.sv
// aes_chain_sequencer
// Autonomous driver around a 128-bit AES core for power-analysis builds.
// It repeatedly loads the core and feeds each ciphertext back as the next
// plaintext. A scope trigger frames every encryption, and a run counter plus
// the last ciphertext keep the core datapath observable.
module aes_chain_sequencer #(
    parameter logic [127:0] SEED       = 128'h00112233445566778899aabbccddeeff,
    parameter logic [31:0]  NUM_RUNS   = 32'd0,
    parameter logic [7:0]   GAP_CYCLES = 8'd4,
    parameter logic [7:0]   TIMEOUT    = 8'd64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic         aes_load_o,
    output logic [127:0] aes_data_o,
    output logic         aes_dec_o,
    input  logic [127:0] aes_data_i,
    input  logic         aes_busy_i,
    output logic         trigger_o,
    output logic [31:0]  count_o,
    output logic [127:0] last_o,
    output logic         done_o,
    output logic         err_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   pt_q, pt_d;
    logic [127:0]   last_q, last_d;
    logic [31:0]    count_q, count_d;
    logic           load_q, load_d;
    logic           trigger_q, trigger_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [7:0]     tmo_q, tmo_d;
    logic [7:0]     gap_q, gap_d;
    logic [31:0]    count_inc_s;
    logic [8:0]     tmo_next_s;

    // Next-state and next-output computation for the sequencing FSM
    always_comb begin
        state_d     = state_q;
        pt_d        = pt_q;
        last_d      = last_q;
        count_d     = count_q;
        done_d      = done_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        count_inc_s = count_q + 32'd1;
        tmo_next_s  = {1'b0, tmo_q} + 9'd1;

        case (state_q)
            ST_IDLE: begin
                if (en_i && !done_q && !err_q) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The core samples the load pulse on the edge leaving this state
                tmo_d   = 8'd0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!aes_busy_i) begin
                    // Ciphertext becomes the next plaintext (chained mode)
                    pt_d    = aes_data_i;
                    last_d  = aes_data_i;
                    count_d = count_inc_s;
                    if ((NUM_RUNS != 32'd0) && (count_inc_s == NUM_RUNS)) begin
                        done_d  = 1'b1;
                        state_d = ST_HALT;
                    end else if (GAP_CYCLES != 8'd0) begin
                        gap_d   = GAP_CYCLES;
                        state_d = ST_GAP;
                    end else if (en_i) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_next_s >= {1'b0, TIMEOUT}) begin
                    // Busy has stayed high for TIMEOUT RUN cycles: give up for good
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    tmo_d = tmo_next_s[7:0];
                end
            end
            ST_GAP: begin
                // gap_q counts the remaining idle cycles, including this one
                if (gap_q <= 8'd1) begin
                    if (en_i) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered
        load_d    = (state_d == ST_LOAD);
        trigger_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pt_q      <= SEED;
            last_q    <= 128'd0;
            count_q   <= 32'd0;
            load_q    <= 1'b0;
            trigger_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 8'd0;
            gap_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            pt_q      <= pt_d;
            last_q    <= last_d;
            count_q   <= count_d;
            load_q    <= load_d;
            trigger_q <= trigger_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
        end
    end

    assign aes_load_o = load_q;
    assign aes_data_o = pt_q;
    assign aes_dec_o  = 1'b0;
    assign trigger_o  = trigger_q;
    assign count_o    = count_q;
    assign last_o     = last_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_aes_chain_sequencer.sv
// Bench for aes_chain_sequencer. Three instances (free-running, NUM_RUNS=3,
// GAP_CYCLES=0) are each paired with a behavioural stand-in core of
// programmable latency. Expected ciphertexts come from iterating the
// stand-in cipher from the seed.
module tb_aes_chain_sequencer;

    localparam logic [127:0] SEED = 128'h00112233445566778899aabbccddeeff;
    localparam int TMO = 64;
    localparam int GAP = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en_s    [3];
    logic         load_s  [3];
    logic [127:0] din_s   [3];
    logic         dec_s   [3];
    logic [127:0] dout_s  [3];
    logic         busy_s  [3];
    logic         trig_s  [3];
    logic [31:0]  cnt_s   [3];
    logic [127:0] last_s  [3];
    logic         done_s  [3];
    logic         err_s   [3];
    logic [127:0] acc_r   [3];
    int           rem_r   [3];
    int           lat_s   [3];
    logic         stuck_s [3];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stand-in cipher: any fixed bijective-looking mix is enough to prove chaining
    function automatic logic [127:0] fake_aes(input logic [127:0] x);
        logic [127:0] r;
        r = {x[94:0], x[127:95]};
        return (r ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0) + {x[63:0], x[127:64]};
    endfunction

    // Reference: n-th ciphertext of the chain started at SEED
    function automatic logic [127:0] chain(input int n);
        logic [127:0] x;
        x = SEED;
        for (int k = 0; k < n; k++) x = fake_aes(x);
        return x;
    endfunction

    aes_chain_sequencer u_free (
        .clk(clk), .rst_n(rst_n), .en_i(en_s[0]), .aes_load_o(load_s[0]),
        .aes_data_o(din_s[0]), .aes_dec_o(dec_s[0]), .aes_data_i(dout_s[0]),
        .aes_busy_i(busy_s[0]), .trigger_o(trig_s[0]), .count_o(cnt_s[0]),
        .last_o(last_s[0]), .done_o(done_s[0]), .err_o(err_s[0]));

    aes_chain_sequencer #(.NUM_RUNS(32'd3)) u_lim (
        .clk(clk), .rst_n(rst_n), .en_i(en_s[1]), .aes_load_o(load_s[1]),
        .aes_data_o(din_s[1]), .aes_dec_o(dec_s[1]), .aes_data_i(dout_s[1]),
        .aes_busy_i(busy_s[1]), .trigger_o(trig_s[1]), .count_o(cnt_s[1]),
        .last_o(last_s[1]), .done_o(done_s[1]), .err_o(err_s[1]));

    aes_chain_sequencer #(.GAP_CYCLES(8'd0)) u_zg (
        .clk(clk), .rst_n(rst_n), .en_i(en_s[2]), .aes_load_o(load_s[2]),
        .aes_data_o(din_s[2]), .aes_dec_o(dec_s[2]), .aes_data_i(dout_s[2]),
        .aes_busy_i(busy_s[2]), .trigger_o(trig_s[2]), .count_o(cnt_s[2]),
        .last_o(last_s[2]), .done_o(done_s[2]), .err_o(err_s[2]));

    // Stand-in cores: busy rises with the load edge, result after lat_s cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                busy_s[i] <= 1'b0;
                dout_s[i] <= 128'd0;
                acc_r[i]  <= 128'd0;
                rem_r[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_s[i]) begin
                    busy_s[i] <= 1'b1;
                    acc_r[i]  <= fake_aes(din_s[i]);
                    rem_r[i]  <= lat_s[i];
                end else if (busy_s[i] && !stuck_s[i]) begin
                    if (rem_r[i] <= 1) begin
                        busy_s[i] <= 1'b0;
                        dout_s[i] <= acc_r[i];
                    end else begin
                        rem_r[i] <= rem_r[i] - 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            en_s[i] = 1'b0;
            stuck_s[i] = 1'b0;
            lat_s[i] = 3;
        end
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_load(input int i, input int budget, output int waited);
        waited = 0;
        while (load_s[i] !== 1'b1 && waited < budget) begin
            step();
            waited++;
        end
    endtask

    task automatic wait_count(input int i, input logic [31:0] target, input int budget,
                              output int waited);
        waited = 0;
        while (cnt_s[i] !== target && waited < budget) begin
            step();
            waited++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_vec++; if (din_s[0] !== SEED) begin n_bad++; $display("FAIL reset_data: got %h want %h", din_s[0], SEED); end
        n_vec++; if (load_s[0] !== 1'b0) begin n_bad++; $display("FAIL reset_load: got %b want 0", load_s[0]); end
        n_vec++; if (dec_s[0] !== 1'b0) begin n_bad++; $display("FAIL reset_dec: got %b want 0", dec_s[0]); end
        n_vec++; if (trig_s[0] !== 1'b0) begin n_bad++; $display("FAIL reset_trigger: got %b want 0", trig_s[0]); end
        n_vec++; if (cnt_s[0] !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt_s[0]); end
        n_vec++; if (last_s[0] !== 128'd0) begin n_bad++; $display("FAIL reset_last: got %h want 0", last_s[0]); end
        n_vec++; if (done_s[0] !== 1'b0 || err_s[0] !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got done=%b err=%b want 0 0", done_s[0], err_s[0]); end
    endtask

    task automatic test_chain();
        int w, l, s;
        logic stable;
        do_reset();
        step(); step();
        n_vec++; if (load_s[0] !== 1'b0 || trig_s[0] !== 1'b0) begin n_bad++; $display("FAIL idle_quiet: got load=%b trig=%b want 0 0", load_s[0], trig_s[0]); end
        en_s[0] = 1'b1;
        step();
        n_vec++; if (load_s[0] !== 1'b1 || trig_s[0] !== 1'b1) begin n_bad++; $display("FAIL first_load: got load=%b trig=%b want 1 1", load_s[0], trig_s[0]); end
        n_vec++; if (din_s[0] !== SEED) begin n_bad++; $display("FAIL first_load_data: got %h want %h", din_s[0], SEED); end
        for (int k = 1; k <= 4; k++) begin
            l = $urandom_range(1, 12);
            lat_s[0] = l;
            s = 0;
            stable = 1'b1;
            while (cnt_s[0] !== k && s < TMO + 20) begin
                if (din_s[0] !== chain(k - 1) || trig_s[0] !== 1'b1) stable = 1'b0;
                step();
                s++;
            end
            n_vec++; if (s !== l + 2) begin n_bad++; $display("FAIL capture_time run %0d: got %0d cycles want %0d", k, s, l + 2); end
            n_vec++; if (stable !== 1'b1) begin n_bad++; $display("FAIL run_stable run %0d: got %b want 1", k, stable); end
            n_vec++; if (last_s[0] !== chain(k) || din_s[0] !== chain(k)) begin n_bad++; $display("FAIL capture_data run %0d: got last=%h pt=%h want %h", k, last_s[0], din_s[0], chain(k)); end
            n_vec++; if (trig_s[0] !== 1'b0) begin n_bad++; $display("FAIL gap_trigger run %0d: got %b want 0", k, trig_s[0]); end
            wait_load(0, 50, w);
            n_vec++; if (w !== GAP || load_s[0] !== 1'b1) begin n_bad++; $display("FAIL gap_len run %0d: got %0d want %0d", k, w, GAP); end
            n_vec++; if (din_s[0] !== chain(k)) begin n_bad++; $display("FAIL load_data run %0d: got %h want %h", k, din_s[0], chain(k)); end
        end
        en_s[0] = 1'b0;
    endtask

    task automatic test_en_drop();
        int w;
        logic quiet;
        do_reset();
        lat_s[0] = 6;
        en_s[0] = 1'b1;
        step();
        step(); step();
        en_s[0] = 1'b0;
        wait_count(0, 32'd1, TMO + 20, w);
        n_vec++; if (cnt_s[0] !== 32'd1 || last_s[0] !== chain(1)) begin n_bad++; $display("FAIL drop_complete: got cnt=%0d last=%h want 1 %h", cnt_s[0], last_s[0], chain(1)); end
        quiet = 1'b1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (load_s[0] !== 1'b0) quiet = 1'b0;
        end
        n_vec++; if (quiet !== 1'b1 || cnt_s[0] !== 32'd1 || trig_s[0] !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got quiet=%b cnt=%0d trig=%b want 1 1 0", quiet, cnt_s[0], trig_s[0]); end
        en_s[0] = 1'b1;
        step();
        n_vec++; if (load_s[0] !== 1'b1 || din_s[0] !== chain(1)) begin n_bad++; $display("FAIL resume_load: got load=%b data=%h want 1 %h", load_s[0], din_s[0], chain(1)); end
        wait_count(0, 32'd2, TMO + 20, w);
        n_vec++; if (last_s[0] !== chain(2)) begin n_bad++; $display("FAIL resume_chain: got %h want %h", last_s[0], chain(2)); end
        en_s[0] = 1'b0;
    endtask

    task automatic test_run_limit();
        int w;
        logic quiet;
        do_reset();
        lat_s[1] = $urandom_range(1, 10);
        en_s[1] = 1'b1;
        w = 0;
        while (done_s[1] !== 1'b1 && w < 500) begin
            step();
            w++;
        end
        n_vec++; if (done_s[1] !== 1'b1 || cnt_s[1] !== 32'd3) begin n_bad++; $display("FAIL limit_done: got done=%b cnt=%0d want 1 3", done_s[1], cnt_s[1]); end
        n_vec++; if (last_s[1] !== chain(3)) begin n_bad++; $display("FAIL limit_last: got %h want %h", last_s[1], chain(3)); end
        quiet = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (load_s[1] !== 1'b0 || trig_s[1] !== 1'b0) quiet = 1'b0;
            step();
        end
        n_vec++; if (quiet !== 1'b1 || cnt_s[1] !== 32'd3 || done_s[1] !== 1'b1) begin n_bad++; $display("FAIL limit_halt: got quiet=%b cnt=%0d done=%b want 1 3 1", quiet, cnt_s[1], done_s[1]); end
        en_s[1] = 1'b0;
    endtask

    task automatic test_zero_gap();
        int s;
        logic trig_ok;
        do_reset();
        en_s[2] = 1'b1;
        step();
        n_vec++; if (load_s[2] !== 1'b1) begin n_bad++; $display("FAIL zg_first_load: got %b want 1", load_s[2]); end
        trig_ok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            lat_s[2] = $urandom_range(1, 8);
            s = 0;
            while (cnt_s[2] !== k && s < TMO + 20) begin
                if (trig_s[2] !== 1'b1) trig_ok = 1'b0;
                step();
                s++;
            end
            n_vec++; if (load_s[2] !== 1'b1 || din_s[2] !== chain(k) || last_s[2] !== chain(k)) begin n_bad++; $display("FAIL zg_reload run %0d: got load=%b data=%h want 1 %h", k, load_s[2], din_s[2], chain(k)); end
        end
        n_vec++; if (trig_ok !== 1'b1) begin n_bad++; $display("FAIL zg_trigger: got %b want 1", trig_ok); end
        en_s[2] = 1'b0;
    endtask

    task automatic test_timeout();
        int w;
        logic quiet;
        do_reset();
        stuck_s[0] = 1'b1;
        en_s[0] = 1'b1;
        wait_load(0, 5, w);
        n_vec++; if (load_s[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_load: got %b want 1", load_s[0]); end
        for (int c = 0; c < TMO; c++) step();
        n_vec++; if (err_s[0] !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got err=%b want 0", err_s[0]); end
        step();
        n_vec++; if (err_s[0] !== 1'b1 || trig_s[0] !== 1'b0 || cnt_s[0] !== 32'd0) begin n_bad++; $display("FAIL tmo_err: got err=%b trig=%b cnt=%0d want 1 0 0", err_s[0], trig_s[0], cnt_s[0]); end
        quiet = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (load_s[0] !== 1'b0) quiet = 1'b0;
        end
        n_vec++; if (quiet !== 1'b1 || err_s[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_halt: got quiet=%b err=%b want 1 1", quiet, err_s[0]); end
        en_s[0] = 1'b0;
    endtask

    task automatic test_async_reset();
        int w;
        do_reset();
        lat_s[0] = 5;
        en_s[0] = 1'b1;
        wait_count(0, 32'd1, TMO + 20, w);
        wait_load(0, 20, w);
        step(); step();
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (din_s[0] !== SEED || cnt_s[0] !== 32'd0 || last_s[0] !== 128'd0) begin n_bad++; $display("FAIL async_rst_data: got pt=%h cnt=%0d last=%h want seed 0 0", din_s[0], cnt_s[0], last_s[0]); end
        n_vec++; if (load_s[0] !== 1'b0 || trig_s[0] !== 1'b0) begin n_bad++; $display("FAIL async_rst_ctrl: got load=%b trig=%b want 0 0", load_s[0], trig_s[0]); end
        #2;
        rst_n = 1'b1;
        wait_load(0, 5, w);
        n_vec++; if (load_s[0] !== 1'b1 || din_s[0] !== SEED) begin n_bad++; $display("FAIL async_restart: got load=%b data=%h want 1 %h", load_s[0], din_s[0], SEED); end
        wait_count(0, 32'd1, TMO + 20, w);
        n_vec++; if (last_s[0] !== chain(1)) begin n_bad++; $display("FAIL async_first_ct: got %h want %h", last_s[0], chain(1)); end
        en_s[0] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            en_s[i] = 1'b0;
            stuck_s[i] = 1'b0;
            lat_s[i] = 3;
        end
        test_reset();
        test_chain();
        test_en_drop();
        test_run_limit();
        test_zero_gap();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
